// File: rtl/alu_core.sv
// alu_core: single-issue ALU execution engine for the ALU_in / ALU_out bus.
// add/and/xor finish in one cycle at full throughput. mul is an iterative
// shift-add unit that takes W cycles and drops `ready` while it runs.
// Optional feature: define ALU_CORE_ILLEGAL_OP_ERR_EN to make reserved opcodes
// (5..7) complete with an `err` pulse. Without it, they behave as no_op.
module alu_core #(
   parameter int ALU_IN_OP_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           alu_rst,
   input  logic                           valid,
   output logic                           ready,
   input  logic [2:0]                     op,
   input  logic [ALU_IN_OP_WIDTH-1:0]     a,
   input  logic [ALU_IN_OP_WIDTH-1:0]     b,
   output logic                           done,
   output logic [2*ALU_IN_OP_WIDTH-1:0]   result,
   output logic                           err
);

   localparam int W  = ALU_IN_OP_WIDTH;
   localparam int RW = 2 * W;
   localparam int CW = $clog2(W + 1);

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;

   typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   count_reg;
   logic [RW-1:0]   mcand_reg;
   logic [W-1:0]    mplier_reg;
   logic [RW-1:0]   acc_reg;
   logic [RW-1:0]   result_reg;
   logic            done_reg;
   logic            err_reg;

   logic [RW-1:0]   addend;
   logic [RW-1:0]   acc_sum;
   logic            accept;
   logic            last_iter;

   assign accept    = valid && ready;
   assign last_iter = (count_reg == CW'(1));

   // Partial product for this iteration: multiplicand gated by the multiplier LSB.
   for (genvar gi = 0; gi < RW; gi++) begin : g_pp
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
   end

   assign acc_sum = acc_reg + addend;

   // State register: IDLE accepts requests, MUL runs the shift-add loop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // Next state: soft clear wins. A mul request enters MUL, and the last iteration returns to IDLE.
   always_comb begin
      state_next = state_reg;
      if (alu_rst) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: if (accept && op == OP_MUL) state_next = ST_MUL;
            ST_MUL:  if (last_iter)              state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Output decode: accept only in IDLE, and never while the soft clear is asserted.
   always_comb begin
      ready = (state_reg == ST_IDLE) && !alu_rst;
   end

   // Datapath: one-cycle ops, mul iterations, and the registered result/done/err outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg  <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         result_reg <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else if (alu_rst) begin
         // Abort any in-flight mul. The partial accumulator is never exposed.
         count_reg  <= '0;
         acc_reg    <= '0;
         result_reg <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         if (accept) begin
            case (op)
               OP_ADD: begin
                  result_reg <= RW'(a) + RW'(b);
                  done_reg   <= 1'b1;
               end
               OP_AND: begin
                  result_reg <= RW'(a & b);
                  done_reg   <= 1'b1;
               end
               OP_XOR: begin
                  result_reg <= RW'(a ^ b);
                  done_reg   <= 1'b1;
               end
               OP_MUL: begin
                  mcand_reg  <= RW'(a);
                  mplier_reg <= b;
                  acc_reg    <= '0;
                  count_reg  <= CW'(W);
               end
               OP_NOP: begin
                  // Accepted but produces nothing.
               end
               default: begin
`ifdef ALU_CORE_ILLEGAL_OP_ERR_EN
                  result_reg <= '0;
                  done_reg   <= 1'b1;
                  err_reg    <= 1'b1;
`endif
               end
            endcase
         end else if (state_reg == ST_MUL) begin
            acc_reg    <= acc_sum;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg - CW'(1);
            if (last_iter) begin
               result_reg <= acc_sum;
               done_reg   <= 1'b1;
            end
         end
      end
   end

   assign done   = done_reg;
   assign result = result_reg;
   assign err    = err_reg;

endmodule
